conf_pkt_gen: RTL

CONF_PKT_GEN -- requirements
Module: conf_pkt_gen

---
 rtl/conf_pkt_gen.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/conf_pkt_gen.sv
// Configuration packet generator: turns block-write / address-only commands into
// hdr-framed beats fed from a synchronous local RAM, and tallies returned packets.
module conf_pkt_gen #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 14,
  parameter int LEN_W  = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_mode,
  input  logic [15:0]         cmd_type,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [MEM_AW-1:0]   cmd_base,
  input  logic [LEN_W-1:0]    cmd_len,
  output logic [MEM_AW-1:0]   mem_rd_addr,
  input  logic [31:0]         mem_rd_data,
  output logic                pkt_valid,
  input  logic                pkt_ready,
  output logic [DATA_W+5:0]   pkt_data,
  input  logic                rsp_valid,
  input  logic [DATA_W+5:0]   rsp_data,
  output logic                busy,
  output logic [15:0]         tx_pkt_cnt,
  output logic [15:0]         rx_pkt_cnt,
  output logic [15:0]         rx_last_type
);

  localparam int PW = DATA_W + 6;
  localparam logic [1:0] HDR_FIRST = 2'b01;
  localparam logic [1:0] HDR_MID   = 2'b11;
  localparam logic [1:0] HDR_LAST  = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_TYPE, S_BODY} state_t;

  state_t              state, state_nxt;
  logic                mode_q;
  logic [15:0]         type_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    idx;
  logic [LEN_W-1:0]    len_last;
  logic [MEM_AW-1:0]   cur_addr, cur_addr_nxt;
  logic [ADDR_W-1:0]   body_addr;
  logic                load, accept;
  logic                beat_load, body_step;
  logic [1:0]          beat_hdr;
  logic [DATA_W-1:0]   beat_payload;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign load      = !pkt_valid || pkt_ready;
  assign len_last  = len_q - LEN_W'(1);
  assign body_addr = addr_q + ADDR_W'(idx);

  always_comb begin
    state_nxt    = state;
    beat_load    = 1'b0;
    beat_hdr     = 2'b00;
    beat_payload = '0;
    body_step    = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) state_nxt = S_HDR0;
      end
      S_HDR0: begin
        if (load) begin
          beat_load = 1'b1;
          beat_hdr  = HDR_FIRST;
          state_nxt = S_HDR1;
        end
      end
      S_HDR1: begin
        if (load) begin
          beat_load = 1'b1;
          beat_hdr  = HDR_MID;
          state_nxt = S_TYPE;
        end
      end
      S_TYPE: begin
        if (load) begin
          beat_load           = 1'b1;
          beat_payload[31:16] = type_q;
          if (!mode_q && (len_q == '0)) begin
            beat_hdr  = HDR_LAST;
            state_nxt = S_IDLE;
          end else begin
            beat_hdr  = HDR_MID;
            state_nxt = S_BODY;
          end
        end
      end
      S_BODY: begin
        if (load) begin
          beat_load = 1'b1;
          if (mode_q) begin
            beat_payload[16 +: ADDR_W] = addr_q;
            beat_hdr  = HDR_LAST;
            state_nxt = S_IDLE;
          end else begin
            beat_payload[16 +: ADDR_W]      = body_addr;
            beat_payload[ADDR_W+16 +: 32]   = mem_rd_data;
            body_step = 1'b1;
            if (idx == len_last) begin
              beat_hdr  = HDR_LAST;
              state_nxt = S_IDLE;
            end else begin
              beat_hdr  = HDR_MID;
            end
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The RAM is addressed with the pointer value for the coming cycle, so the word
  // for the next body beat is already on mem_rd_data when that beat loads.
  always_comb begin
    cur_addr_nxt = cur_addr;
    if (accept)
      cur_addr_nxt = cmd_base;
    else if (body_step)
      cur_addr_nxt = cur_addr + MEM_AW'(1);
  end

  assign mem_rd_addr = reset ? '0 : cur_addr_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cur_addr   <= '0;
      mode_q     <= 1'b0;
      len_q      <= '0;
      idx        <= '0;
      pkt_valid  <= 1'b0;
      pkt_data   <= '0;
      tx_pkt_cnt <= '0;
    end else begin
      state    <= state_nxt;
      cur_addr <= cur_addr_nxt;
      if (accept) begin
        mode_q <= cmd_mode;
        len_q  <= cmd_len;
        idx    <= '0;
      end else if (body_step) begin
        idx <= idx + LEN_W'(1);
      end
      if (load) begin
        pkt_valid <= beat_load;
        if (beat_load) pkt_data <= {beat_hdr, 4'b0000, beat_payload};
      end
      if (pkt_valid && pkt_ready && (pkt_data[PW-1 -: 2] == HDR_LAST))
        tx_pkt_cnt <= tx_pkt_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      type_q <= cmd_type;
      addr_q <= cmd_addr;
    end
  end

  // Response monitor: rx_idx is the index of the incoming beat, saturating at 3.
  logic [1:0]  rsp_hdr;
  logic [15:0] rsp_type;
  logic        rx_open;
  logic [1:0]  rx_idx;
  logic [15:0] rx_type;
  logic        unused_rsp;

  assign rsp_hdr    = rsp_data[PW-1 -: 2];
  assign rsp_type   = rsp_data[31:16];
  assign unused_rsp = &{1'b0, rsp_data[PW-3:32], rsp_data[15:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_open      <= 1'b0;
      rx_idx       <= '0;
      rx_type      <= '0;
      rx_pkt_cnt   <= '0;
      rx_last_type <= '0;
    end else if (rsp_valid) begin
      case (rsp_hdr)
        HDR_FIRST: begin
          rx_open <= 1'b1;
          rx_idx  <= 2'd1;
          rx_type <= '0;
        end
        HDR_MID: begin
          if (rx_open) begin
            if (rx_idx == 2'd2) rx_type <= rsp_type;
            if (rx_idx != 2'd3) rx_idx <= rx_idx + 2'd1;
          end
        end
        HDR_LAST: begin
          if (rx_open) begin
            rx_open      <= 1'b0;
            rx_pkt_cnt   <= rx_pkt_cnt + 16'd1;
            rx_last_type <= (rx_idx == 2'd2) ? rsp_type : rx_type;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
